// File: rtl/matmul_seq_engine_if.sv
// Memory-side bus of the matrix engine: one shared read strobe for the A/B read ports
// plus a single write port for C.
interface matmul_seq_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en,
        output rd_addr_a,
        output rd_addr_b,
        input  rd_data_a,
        input  rd_data_b,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr_a,
        input  rd_addr_b,
        output rd_data_a,
        output rd_data_b,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/matmul_seq_engine.sv
// Sequential C = A x B engine (i outer, j middle, k inner) over a fixed-latency
// dual-read memory; each C element is accumulated internally and written once.
module matmul_seq_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DIM_W      = 16,
    parameter int MEM_LAT    = 1,
    parameter int BYTE_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [ADDR_W-1:0]    base_a,
    input  logic [ADDR_W-1:0]    base_b,
    input  logic [ADDR_W-1:0]    base_c,
    input  logic [DIM_W-1:0]     num_i,
    input  logic [DIM_W-1:0]     num_j,
    input  logic [DIM_W-1:0]     num_k,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    matmul_seq_engine_if.master  mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0]  ELEM_STEP = ADDR_W'(1) << BYTE_SHIFT;
    localparam logic [MEM_LAT-1:0] TOP_MASK  = MEM_LAT'(1) << (MEM_LAT - 1);

    state_t state_reg;
    state_t state_next;

    logic [DIM_W-1:0]  i_reg;
    logic [DIM_W-1:0]  j_reg;
    logic [DIM_W-1:0]  k_reg;
    logic [DIM_W-1:0]  ni_reg;
    logic [DIM_W-1:0]  nj_reg;
    logic [DIM_W-1:0]  nk_reg;
    logic              signed_reg;
    logic              err_reg;
    logic [DATA_W-1:0] acc_reg;

    // Addresses are walked incrementally: strides replace the i*num_k / k*num_j products.
    logic [ADDR_W-1:0] base_b_reg;
    logic [ADDR_W-1:0] stride_a_reg;
    logic [ADDR_W-1:0] stride_b_reg;
    logic [ADDR_W-1:0] row_a_reg;
    logic [ADDR_W-1:0] col_b_reg;
    logic [ADDR_W-1:0] addr_a_reg;
    logic [ADDR_W-1:0] addr_b_reg;
    logic [ADDR_W-1:0] addr_c_reg;

    logic [MEM_LAT-1:0] vld_reg;
    logic [MEM_LAT-1:0] vld_next;
    logic [MEM_LAT-1:0] fst_reg;
    logic [MEM_LAT-1:0] fst_next;

    logic              issue;
    logic              zero_dim;
    logic              k_last;
    logic              j_last;
    logic              i_last;
    logic              early_pending;
    logic              ret_valid;
    logic              ret_first;
    logic [DATA_W-1:0] prod;

    assign issue         = (state_reg == S_ISSUE);
    assign zero_dim      = (num_i == '0) || (num_j == '0) || (num_k == '0);
    assign k_last        = (k_reg == nk_reg - DIM_W'(1));
    assign j_last        = (j_reg == nj_reg - DIM_W'(1));
    assign i_last        = (i_reg == ni_reg - DIM_W'(1));
    assign early_pending = |(vld_reg & ~TOP_MASK);
    assign ret_valid     = vld_reg[MEM_LAT-1];
    assign ret_first     = fst_reg[MEM_LAT-1];

    // Valid/first-of-element tags travel alongside each read for MEM_LAT cycles.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign vld_next[gi] = issue;
                assign fst_next[gi] = issue && (k_reg == '0);
            end else begin : g_tail
                assign vld_next[gi] = vld_reg[gi-1];
                assign fst_next[gi] = fst_reg[gi-1];
            end
        end
    endgenerate

    // Low DATA_W bits of the product; signedness is kept explicit for readability.
    always_comb begin
        prod = '0;
        if (signed_reg) begin
            prod = DATA_W'($signed(mem.rd_data_a) * $signed(mem.rd_data_b));
        end else begin
            prod = mem.rd_data_a * mem.rd_data_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        busy          = 1'b0;
        done          = 1'b0;
        mem.rd_en     = 1'b0;
        mem.wr_en     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = zero_dim ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                mem.rd_en = 1'b1;
                if (k_last) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave once only the oldest read remains; it is absorbed on this edge.
                if (!early_pending) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy       = 1'b1;
                mem.wr_en  = 1'b1;
                state_next = (i_last && j_last) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_reg <= '0;
            fst_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            fst_reg <= fst_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
            ni_reg       <= '0;
            nj_reg       <= '0;
            nk_reg       <= '0;
            signed_reg   <= 1'b0;
            err_reg      <= 1'b0;
            acc_reg      <= '0;
            base_b_reg   <= '0;
            stride_a_reg <= '0;
            stride_b_reg <= '0;
            row_a_reg    <= '0;
            col_b_reg    <= '0;
            addr_a_reg   <= '0;
            addr_b_reg   <= '0;
            addr_c_reg   <= '0;
        end else begin
            if (ret_valid) begin
                acc_reg <= ret_first ? prod : acc_reg + prod;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        ni_reg       <= num_i;
                        nj_reg       <= num_j;
                        nk_reg       <= num_k;
                        signed_reg   <= is_signed;
                        err_reg      <= zero_dim;
                        i_reg        <= '0;
                        j_reg        <= '0;
                        k_reg        <= '0;
                        acc_reg      <= '0;
                        base_b_reg   <= base_b;
                        stride_a_reg <= ADDR_W'(num_k) << BYTE_SHIFT;
                        stride_b_reg <= ADDR_W'(num_j) << BYTE_SHIFT;
                        row_a_reg    <= base_a;
                        col_b_reg    <= base_b;
                        addr_a_reg   <= base_a;
                        addr_b_reg   <= base_b;
                        addr_c_reg   <= base_c;
                    end
                end
                S_ISSUE: begin
                    k_reg      <= k_reg + DIM_W'(1);
                    addr_a_reg <= addr_a_reg + ELEM_STEP;
                    addr_b_reg <= addr_b_reg + stride_b_reg;
                end
                S_WRITE: begin
                    acc_reg    <= '0;
                    k_reg      <= '0;
                    addr_c_reg <= addr_c_reg + ELEM_STEP;
                    if (j_last) begin
                        j_reg      <= '0;
                        i_reg      <= i_reg + DIM_W'(1);
                        row_a_reg  <= row_a_reg + stride_a_reg;
                        addr_a_reg <= row_a_reg + stride_a_reg;
                        col_b_reg  <= base_b_reg;
                        addr_b_reg <= base_b_reg;
                    end else begin
                        j_reg      <= j_reg + DIM_W'(1);
                        addr_a_reg <= row_a_reg;
                        col_b_reg  <= col_b_reg + ELEM_STEP;
                        addr_b_reg <= col_b_reg + ELEM_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err           = err_reg;
    assign mem.rd_addr_a = addr_a_reg;
    assign mem.rd_addr_b = addr_b_reg;
    assign mem.wr_addr   = addr_c_reg;
    assign mem.wr_data   = acc_reg;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench for matmul_seq_engine: two instances (MEM_LAT 1 and 3) share one
// word memory; expected C writes are queued at job launch and popped as they appear.
module tb_matmul_seq_engine;

    localparam logic [31:0] BA = 32'h000;
    localparam logic [31:0] BB = 32'h040;
    localparam logic [31:0] BC = 32'h100;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start3;
    logic        is_signed;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [31:0] base_c;
    logic [15:0] num_i;
    logic [15:0] num_j;
    logic [15:0] num_k;
    logic        busy1, done1, err1;
    logic        busy3, done3, err3;

    logic [31:0] mem [256];
    logic [31:0] pa1, pb1;
    logic [31:0] pa3 [3];
    logic [31:0] pb3 [3];

    wr_t sb[$];
    int  n_assert;
    int  n_fail;
    logic use_lat3;

    matmul_seq_engine_if #(.DATA_W(32), .ADDR_W(32)) m1 ();
    matmul_seq_engine_if #(.DATA_W(32), .ADDR_W(32)) m3 ();

    matmul_seq_engine #(.DATA_W(32), .ADDR_W(32), .DIM_W(16), .MEM_LAT(1), .BYTE_SHIFT(2)) d1 (
        .clk(clk), .reset(rst_n), .start(start1), .is_signed(is_signed),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .num_i(num_i), .num_j(num_j), .num_k(num_k),
        .busy(busy1), .done(done1), .err(err1), .mem(m1)
    );

    matmul_seq_engine #(.DATA_W(32), .ADDR_W(32), .DIM_W(16), .MEM_LAT(3), .BYTE_SHIFT(2)) d3 (
        .clk(clk), .reset(rst_n), .start(start3), .is_signed(is_signed),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .num_i(num_i), .num_j(num_j), .num_k(num_k),
        .busy(busy3), .done(done3), .err(err3), .mem(m3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pa1    <= mem[m1.rd_addr_a[9:2]];
        pb1    <= mem[m1.rd_addr_b[9:2]];
        pa3[0] <= mem[m3.rd_addr_a[9:2]];
        pb3[0] <= mem[m3.rd_addr_b[9:2]];
        pa3[1] <= pa3[0];
        pb3[1] <= pb3[0];
        pa3[2] <= pa3[1];
        pb3[2] <= pb3[1];
    end

    assign m1.rd_data_a = pa1;
    assign m1.rd_data_b = pb1;
    assign m3.rd_data_a = pa3[2];
    assign m3.rd_data_b = pb3[2];

    logic        cur_done, cur_busy, cur_err, cur_rd_en, cur_wr_en;
    logic [31:0] cur_wr_addr, cur_wr_data;
    assign cur_done    = use_lat3 ? done3 : done1;
    assign cur_busy    = use_lat3 ? busy3 : busy1;
    assign cur_err     = use_lat3 ? err3 : err1;
    assign cur_rd_en   = use_lat3 ? m3.rd_en : m1.rd_en;
    assign cur_wr_en   = use_lat3 ? m3.wr_en : m1.wr_en;
    assign cur_wr_addr = use_lat3 ? m3.wr_addr : m1.wr_addr;
    assign cur_wr_data = use_lat3 ? m3.wr_data : m1.wr_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mem();
        for (int w = 0; w < 256; w++) mem[w] = 32'h0;
    endtask

    // Reference product computed straight from the row-major definition.
    task automatic push_expected(input int ni, input int nj, input int nk);
        logic [31:0] acc, a, b;
        wr_t e;
        for (int i = 0; i < ni; i++) begin
            for (int j = 0; j < nj; j++) begin
                acc = 32'h0;
                for (int k = 0; k < nk; k++) begin
                    a   = mem[(BA >> 2) + 32'(i * nk + k)];
                    b   = mem[(BB >> 2) + 32'(k * nj + j)];
                    acc = acc + a * b;
                end
                e.addr = BC + 32'((i * nj + j) << 2);
                e.data = acc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_job(input bit lat3, input int ni, input int nj, input int nk,
                           input bit sgn, input int poke);
        int  lat, exp_cyc, exp_rd, exp_wr, cyc, nrd, nwr;
        bit  zero, seen;
        wr_t e;
        lat     = lat3 ? 3 : 1;
        zero    = (ni == 0) || (nj == 0) || (nk == 0);
        exp_cyc = zero ? 1 : ni * nj * (nk + lat + 1) + 1;
        exp_rd  = zero ? 0 : ni * nj * nk;
        exp_wr  = zero ? 0 : ni * nj;
        num_i = 16'(ni); num_j = 16'(nj); num_k = 16'(nk);
        is_signed = sgn; base_a = BA; base_b = BB; base_c = BC;
        if (!zero) push_expected(ni, nj, nk);
        use_lat3 = lat3;
        if (lat3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        cyc = 1; seen = 0; nrd = 0; nwr = 0;
        while (!seen && cyc <= exp_cyc + 40) begin
            check("rd_wr_overlap", {63'h0, cur_rd_en & cur_wr_en}, 64'h0);
            if (cur_wr_en) begin
                nwr++;
                check("write_expected", {63'h0, sb.size() != 0}, 64'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", {32'h0, cur_wr_addr}, {32'h0, e.addr});
                    check("wr_data", {32'h0, cur_wr_data}, {32'h0, e.data});
                    $display("write cyc=%0d addr=%08h data=%08h", cyc, cur_wr_addr, cur_wr_data);
                end
            end
            if (cur_rd_en) nrd++;
            if (cyc == poke) begin
                if (lat3) start3 = 1'b1; else start1 = 1'b1;
                num_i = 16'd7; num_k = 16'd0; base_c = 32'h3F0;
            end else begin
                start1 = 1'b0; start3 = 1'b0;
            end
            if (cur_done) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        start1 = 1'b0; start3 = 1'b0;
        check("done_seen", {63'h0, seen}, 64'h1);
        check("done_cycle", 64'(cyc), 64'(exp_cyc));
        check("err_with_done", {63'h0, cur_err}, {63'h0, zero});
        check("rd_count", 64'(nrd), 64'(exp_rd));
        check("wr_count", 64'(nwr), 64'(exp_wr));
        check("queue_drained", 64'(sb.size()), 64'h0);
        $display("job lat=%0d ni=%0d nj=%0d nk=%0d sgn=%0d done_cyc=%0d reads=%0d writes=%0d",
                 lat, ni, nj, nk, sgn, cyc, nrd, nwr);
        @(negedge clk);
        check("done_single_pulse", {63'h0, cur_done}, 64'h0);
        check("idle_not_busy", {63'h0, cur_busy}, 64'h0);
        check("err_holds", {63'h0, cur_err}, {63'h0, zero});
        check("idle_no_write", {63'h0, cur_wr_en}, 64'h0);
    endtask

    task automatic load_2x2();
        clear_mem();
        mem[0] = 1;  mem[1] = 2;  mem[2] = 3;  mem[3] = 4;
        mem[16] = 5; mem[17] = 6; mem[18] = 7; mem[19] = 8;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; use_lat3 = 1'b0;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; is_signed = 1'b0;
        base_a = '0; base_b = '0; base_c = '0; num_i = '0; num_j = '0; num_k = '0;
        clear_mem();
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'h0, busy1 | busy3}, 64'h0);
        check("rst_done", {63'h0, done1 | done3}, 64'h0);
        check("rst_err", {63'h0, err1 | err3}, 64'h0);
        check("rst_rd_en", {63'h0, m1.rd_en | m3.rd_en}, 64'h0);
        check("rst_wr_en", {63'h0, m1.wr_en | m3.wr_en}, 64'h0);
        check("rst_addr", {m1.rd_addr_a | m1.rd_addr_b, m1.wr_addr | m3.wr_addr}, 64'h0);
        check("rst_wr_data", {m1.wr_data, m3.wr_data}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x2x2 basic, then the same job again with a start poked mid-run.
        load_2x2();
        run_job(1'b0, 2, 2, 2, 1'b0, 0);
        run_job(1'b0, 2, 2, 2, 1'b0, 5);

        // Non-square 1x3 by 3x2 on the three-cycle memory.
        clear_mem();
        mem[0] = 1; mem[1] = 2; mem[2] = 3;
        mem[16] = 1; mem[17] = 0; mem[18] = 0; mem[19] = 1; mem[20] = 1; mem[21] = 1;
        run_job(1'b1, 1, 2, 3, 1'b0, 0);

        // Signed -2 * 3, then unsigned wrap of 0xFFFFFFFF*2 + 3*1.
        clear_mem();
        mem[0] = 32'hFFFF_FFFE; mem[16] = 32'd3;
        run_job(1'b0, 1, 1, 1, 1'b1, 0);
        clear_mem();
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd3; mem[16] = 32'd2; mem[17] = 32'd1;
        run_job(1'b0, 1, 1, 2, 1'b0, 0);

        // Zero inner dimension: immediate done with err, no traffic.
        run_job(1'b0, 2, 2, 0, 1'b0, 0);
        run_job(1'b1, 0, 3, 2, 1'b0, 0);

        // Abort in DRAIN on the three-cycle instance, then rerun from scratch.
        load_2x2();
        use_lat3 = 1'b1;
        num_i = 16'd2; num_j = 16'd2; num_k = 16'd2; is_signed = 1'b0;
        base_a = BA; base_b = BB; base_c = BC;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("drain_busy", {63'h0, busy3}, 64'h1);
        check("drain_no_rd", {63'h0, m3.rd_en}, 64'h0);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'h0, busy3}, 64'h0);
        check("abort_wr_en", {63'h0, m3.wr_en}, 64'h0);
        check("abort_wr_data", {32'h0, m3.wr_data}, 64'h0);
        $display("reset asserted mid-drain at %0t", $time);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_hold_wr", {63'h0, m3.wr_en | done3}, 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {63'h0, busy3 | m3.wr_en | m3.rd_en}, 64'h0);
        run_job(1'b1, 2, 2, 2, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_seq_engine.md
Name: matmul_seq_engine

Overview:
- Parametrised, pipelined successor to the single-step matrix datapath.
- Computes C = A x B without external help. A is num_i x num_k, B is num_k x num_j, C is num_i x num_j, all row-major in word-addressed memory.
- Loop order: i outer, j middle, k inner. Products are accumulated internally; C[i][j] is written exactly once, with no read-modify-write.
- Sits between the control FSM (start/done) and a dual-read, single-write memory with fixed read latency.

Parameters:
- DATA_W, 32, element and accumulator width.
- ADDR_W, 32, byte-address width.
- DIM_W, 16, width of each dimension and loop counter.
- MEM_LAT, 1, read latency in cycles (>=1) from rd_en to rd_data valid.
- BYTE_SHIFT, 2, log2 bytes per element.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- is_signed  in  1  1 = signed multiply; latched at start.
- base_a  in  ADDR_W  base address of A; latched at start.
- base_b  in  ADDR_W  base address of B; latched at start.
- base_c  in  ADDR_W  base address of C; latched at start.
- num_i  in  DIM_W  rows of A and C; latched at start.
- num_j  in  DIM_W  columns of B and C; latched at start.
- num_k  in  DIM_W  columns of A, rows of B; latched at start.
- busy  out  1  high from the first ISSUE cycle through the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = a dimension was zero and nothing was computed.
- rd_en  out  1  read request for both A and B ports.
- rd_addr_a  out  ADDR_W  byte address of A[i][k].
- rd_addr_b  out  ADDR_W  byte address of B[k][j].
- rd_data_a  in  DATA_W  A element, valid MEM_LAT cycles after rd_en.
- rd_data_b  in  DATA_W  B element, valid MEM_LAT cycles after rd_en.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  byte address of C[i][j].
- wr_data  out  DATA_W  final accumulated sum.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; i, j, k, accumulator and the valid shift register all 0.
  - busy, done, err, rd_en and wr_en are 0; all address and data outputs are 0.
  - Reset mid-operation aborts immediately; returning read data is discarded and no write is issued.
- Address arithmetic is done modulo 2^ADDR_W:
  - rd_addr_a = base_a + ((i*num_k + k) << BYTE_SHIFT)
  - rd_addr_b = base_b + ((k*num_j + j) << BYTE_SHIFT)
  - wr_addr = base_c + ((i*num_j + j) << BYTE_SHIFT)
- Product is the low DATA_W bits of rd_data_a*rd_data_b, signed or unsigned per the latched is_signed. Accumulation wraps modulo 2^DATA_W; there is no saturation and no overflow flag.
- FSM states:
  - IDLE: on start=1, latch all config. If any dimension is 0, go to DONE with err=1. Otherwise go to ISSUE with i=j=k=0 and acc=0.
  - ISSUE: assert rd_en for the current k, then k++. After issuing k=num_k-1, go to DRAIN.
  - DRAIN: rd_en=0. Stay until all in-flight reads have returned, MEM_LAT cycles after the last issue.
  - WRITE: one cycle with wr_en=1 and wr_data=acc. Clear acc and k. Advance j; when j wraps, advance i. If i was the last row and j the last column, go to DONE; otherwise go to ISSUE.
  - DONE: done=1 for one cycle, then IDLE. err holds its value until the next start.
- Accumulation: a MEM_LAT-deep valid shift register tracks issued reads. acc += product in every cycle where the delayed valid is 1. The first return of an element loads acc = product, so no stale sum carries over.
- Timing:
  - Each C element takes num_k + MEM_LAT + 1 cycles.
  - done is asserted num_i*num_j*(num_k+MEM_LAT+1) + 1 cycles after the start edge.
  - Zero-dimension case: done arrives 1 cycle after the start edge.
- start is ignored outside IDLE. Config inputs may change freely while busy.
- wr_en and rd_en are never high in the same cycle.

Test Plan:
- Basic 2x2x2 case: MEM_LAT=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]], base_c=0x100 -> writes 19, 22, 43, 50 at 0x100, 0x104, 0x108, 0x10C in that order. done arrives 17 cycles after start; exactly 4 writes and 8 rd_en cycles.
- Non-square 1x3 by 3x2 with MEM_LAT=3: A=[1,2,3], B=[[1,0],[0,1],[1,1]] -> C=[4,5]. Each element takes 7 cycles and done arrives at cycle 15.
- Signed wrap: is_signed=1, A=[-2], B=[3] -> 0xFFFFFFFA. Unsigned 0xFFFFFFFF*2 -> 0xFFFFFFFE; the accumulator wraps with no flag.
- Zero dimension: num_k=0 -> done and err high 1 cycle after start; no rd_en or wr_en at any point.
- start pulsed while busy is ignored: exactly one done pulse and unchanged write count. A second start after done runs a fresh job with acc starting from 0.
- Reset: asserting reset=0 in the middle of DRAIN drives busy=0 and wr_en=0 asynchronously. After release, state is IDLE and a full rerun produces correct results.
